// File: rtl/ysyx_24070016_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 memory-op encodings,
// completion error codes and the transaction state type.
package ysyx_24070016_lsu_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_BUS     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

    // Zero-extending loads have no store counterpart.
    function automatic logic is_load_only(input logic [2:0] op);
        return (op == OP_BU) || (op == OP_HU);
    endfunction

endpackage

// File: rtl/ysyx_24070016_lsu_if.sv
// Data-memory bus: one request channel (valid/ready) and a single-cycle
// response pulse. The LSU is the master.
interface ysyx_24070016_lsu_if;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_wen;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        bus_resp_err;

    modport master (
        output bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
    );

    modport slave (
        input  bus_req_valid, bus_req_wen, bus_req_addr, bus_req_wdata, bus_req_wstrb,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
    );

endinterface

// File: rtl/ysyx_24070016_lsu_align.sv
// Byte-lane steering for the LSU: store strobes/data placement, load data
// extraction with sign/zero extension, and alignment/opcode legality.
module ysyx_24070016_lsu_align
    import ysyx_24070016_lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_wdata,
    output logic [31:0] ext_rdata,
    output logic        misaligned
);

    logic [4:0]  sh;
    logic [15:0] d;

    assign sh         = {addr_lo, 3'b000};
    assign d          = 16'(rdata >> sh);
    assign lane_wdata = wdata << sh;

    always_comb begin
        wstrb      = '0;
        ext_rdata  = '0;
        misaligned = 1'b0;
        case (op)
            OP_B: begin
                wstrb     = 4'b0001 << addr_lo;
                ext_rdata = {{24{d[7]}}, d[7:0]};
            end
            OP_BU: begin
                wstrb     = 4'b0001 << addr_lo;
                ext_rdata = {24'b0, d[7:0]};
            end
            OP_H: begin
                wstrb      = 4'b0011 << addr_lo;
                ext_rdata  = {{16{d[15]}}, d};
                misaligned = addr_lo[0];
            end
            OP_HU: begin
                wstrb      = 4'b0011 << addr_lo;
                ext_rdata  = {16'b0, d};
                misaligned = addr_lo[0];
            end
            OP_W: begin
                wstrb      = '1;
                ext_rdata  = rdata;
                misaligned = |addr_lo;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_24070016_lsu.sv
// Load/store unit: single outstanding memory transaction from EXU to the
// data bus, with alignment checking, response timeout and result hand-off to WBU.
module ysyx_24070016_lsu
    import ysyx_24070016_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_wren,
    input  logic [2:0]                in_op,
    input  logic [31:0]               in_addr,
    input  logic [31:0]               in_wdata,
    input  logic [4:0]                in_rd,
    ysyx_24070016_lsu_if.master       bus,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_rdata,
    output logic [4:0]                out_rd,
    output logic [1:0]                out_err
);

    lsu_state_e  state_q, state_d;
    lsu_err_e    err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wren_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic        capture;

    logic [2:0]  sel_op;
    logic [1:0]  sel_lo;
    logic [3:0]  wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] ext_rdata;
    logic        misaligned;
    logic        illegal;

    // One align unit serves both the accept-time legality check (live inputs
    // in IDLE) and the later bus/response stages (latched op and address).
    assign sel_op = (state_q == IDLE) ? in_op        : op_q;
    assign sel_lo = (state_q == IDLE) ? in_addr[1:0] : addr_q[1:0];

    ysyx_24070016_lsu_align u_align (
        .op         (sel_op),
        .addr_lo    (sel_lo),
        .wdata      (wdata_q),
        .rdata      (bus.bus_resp_rdata),
        .wstrb      (wstrb),
        .lane_wdata (lane_wdata),
        .ext_rdata  (ext_rdata),
        .misaligned (misaligned)
    );

    assign illegal = misaligned | (in_wren & is_load_only(in_op));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (illegal) begin
                        err_d   = ERR_ALIGN;
                        state_d = DONE;
                    end else begin
                        err_d   = ERR_OK;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.bus_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response in the timeout cycle still completes normally.
                if (bus.bus_resp_valid) begin
                    state_d = DONE;
                    if (bus.bus_resp_err) begin
                        err_d   = ERR_BUS;
                        rdata_d = '0;
                    end else begin
                        err_d   = ERR_OK;
                        rdata_d = wren_q ? '0 : ext_rdata;
                    end
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    err_d   = ERR_TIMEOUT;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
            rdata_q <= '0;
            wren_q  <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (capture) begin
                wren_q  <= in_wren;
                op_q    <= in_op;
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
                rd_q    <= in_rd;
            end
        end
    end

    assign in_ready          = (state_q == IDLE);
    assign bus.bus_req_valid = (state_q == REQ);
    assign bus.bus_req_wen   = (state_q == REQ) & wren_q;
    assign bus.bus_req_addr  = (state_q == REQ) ? {addr_q[31:2], 2'b00} : '0;
    assign bus.bus_req_wdata = ((state_q == REQ) && wren_q) ? lane_wdata : '0;
    assign bus.bus_req_wstrb = ((state_q == REQ) && wren_q) ? wstrb : '0;

    assign out_valid = (state_q == DONE);
    assign out_rdata = (state_q == DONE) ? rdata_q : '0;
    assign out_rd    = (state_q == DONE) ? rd_q : '0;
    assign out_err   = (state_q == DONE) ? err_q : ERR_OK;

endmodule

// File: tb/tb_ysyx_24070016_lsu.sv
// Self-checking bench for ysyx_24070016_lsu: directed scenarios followed by
// randomized transactions against a byte-arithmetic reference model.
module tb_ysyx_24070016_lsu;

    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_wren;
    logic [2:0]  in_op;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic [1:0]  out_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    ysyx_24070016_lsu_if bus ();

    ysyx_24070016_lsu #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wren   (in_wren),
        .in_op     (in_op),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_rd     (in_rd),
        .bus       (bus.master),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata (out_rdata),
        .out_rd    (out_rd),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference rules, written from access size and byte offset.
    function automatic bit ref_illegal(input bit wren, input logic [2:0] op, input logic [31:0] addr);
        case (op)
            3'd0:    return 1'b0;
            3'd1:    return addr[0];
            3'd2:    return addr[1:0] != 2'd0;
            3'd4:    return wren;
            3'd5:    return wren || addr[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input bit wren, input logic [2:0] op, input logic [31:0] addr);
        int unsigned nbytes, off;
        if (!wren) return 4'b0000;
        nbytes = 1 << op[1:0];
        off    = addr[1:0];
        return 4'(((1 << nbytes) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rdata);
        longint v;
        int unsigned off;
        off = addr[1:0];
        v   = longint'(rdata) / (longint'(1) << (8 * off));
        case (op)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'd4: v = v % 256;
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'd5: v = v % 65536;
            default: v = longint'(rdata);
        endcase
        return 32'(v);
    endfunction

    task automatic quiet_inputs();
        in_valid = 1'b0;
        out_ready = 1'b0;
        bus.bus_req_ready = 1'b0;
        bus.bus_resp_valid = 1'b0;
        bus.bus_resp_err = 1'b0;
    endtask

    // Pulls reset between clock edges and expects the idle picture at once.
    task automatic async_reset(input string where);
        #2 rst_n = 1'b0;
        #1;
        check({where, "_rst_in_ready"}, in_ready, 1);
        check({where, "_rst_req_valid"}, bus.bus_req_valid, 0);
        check({where, "_rst_out_valid"}, out_valid, 0);
        check({where, "_rst_out_err"}, out_err, 0);
        check({where, "_rst_out_rdata"}, out_rdata, 0);
        quiet_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // abort_at: 0 none, 1 reset in REQ, 2 reset in WAIT, 3 reset in DONE.
    task automatic txn(input bit wren, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                       input bit rerr, input bit noresp, input int unsigned req_dly,
                       input int unsigned resp_dly, input int unsigned out_dly,
                       input int unsigned abort_at);
        bit          ill;
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
        ill = ref_illegal(wren, op, addr);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_wren  = wren;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wdata;
        in_rd    = rd;
        @(negedge clk);
        in_valid = 1'b0;
        in_wren  = 1'($urandom);
        in_op    = 3'($urandom);
        in_addr  = $urandom;
        in_wdata = $urandom;
        in_rd    = 5'($urandom);
        check("in_ready_busy", in_ready, 0);
        if (ill) begin
            e_err   = 2'b01;
            e_rdata = 32'h0;
            check("illegal_no_req", bus.bus_req_valid, 0);
        end else begin
            check("req_valid", bus.bus_req_valid, 1);
            check("req_wen", bus.bus_req_wen, wren);
            check("req_addr", bus.bus_req_addr, addr & 32'hFFFF_FFFC);
            check("req_wstrb", bus.bus_req_wstrb, ref_strb(wren, op, addr));
            if (wren) check("req_wdata", bus.bus_req_wdata, wdata << (8 * addr[1:0]));
            if (abort_at == 1) begin async_reset("req"); return; end
            for (int i = 0; i < int'(req_dly); i++) begin
                @(negedge clk);
                check("req_hold_valid", bus.bus_req_valid, 1);
                check("req_hold_addr", bus.bus_req_addr, addr & 32'hFFFF_FFFC);
                check("req_hold_wstrb", bus.bus_req_wstrb, ref_strb(wren, op, addr));
            end
            bus.bus_req_ready = 1'b1;
            @(negedge clk);
            bus.bus_req_ready = 1'b0;
            check("req_single", bus.bus_req_valid, 0);
            if (abort_at == 2) begin async_reset("wait"); return; end
            if (noresp) begin
                repeat (TO - 1) @(negedge clk);
                check("pre_timeout_idle", out_valid, 0);
                @(negedge clk);
                e_err   = 2'b11;
                e_rdata = 32'h0;
            end else begin
                repeat (resp_dly) @(negedge clk);
                check("no_early_out", out_valid, 0);
                bus.bus_resp_valid = 1'b1;
                bus.bus_resp_rdata = rdata;
                bus.bus_resp_err   = rerr;
                @(negedge clk);
                bus.bus_resp_valid = 1'b0;
                bus.bus_resp_err   = 1'b0;
                bus.bus_resp_rdata = $urandom;
                e_err   = rerr ? 2'b10 : 2'b00;
                e_rdata = (rerr || wren) ? 32'h0 : ref_load(op, addr, rdata);
            end
        end
        check("out_valid", out_valid, 1);
        check("out_err", out_err, e_err);
        check("out_rdata", out_rdata, e_rdata);
        check("out_rd", out_rd, rd);
        if (noresp && !ill) begin
            bus.bus_resp_valid = 1'b1;
            bus.bus_resp_rdata = $urandom;
            @(negedge clk);
            bus.bus_resp_valid = 1'b0;
            check("late_resp_err", out_err, 2'b11);
            check("late_resp_rdata", out_rdata, 0);
        end
        if (abort_at == 3) begin async_reset("done"); return; end
        for (int i = 0; i < int'(out_dly); i++) begin
            @(negedge clk);
            check("out_hold_valid", out_valid, 1);
            check("out_hold_rdata", out_rdata, e_rdata);
            check("out_hold_err", out_err, e_err);
            check("out_hold_no_accept", in_ready, 0);
            check("out_hold_no_req", bus.bus_req_valid, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_released", out_valid, 0);
        check("back_idle", in_ready, 1);
    endtask

    initial begin
        logic [2:0] legal_ops [5];
        bit          wren, rerr, noresp;
        logic [2:0]  op;
        logic [31:0] addr;
        legal_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0;
        quiet_inputs();
        in_wren = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0; in_rd = '0;
        bus.bus_resp_rdata = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_req_valid", bus.bus_req_valid, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_rdata", out_rdata, 0);
        check("reset_out_err", out_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // lb from the top byte lane, sign extension.
        txn(0, 3'd0, 32'h8000_0003, 32'h0, 5'd7, 32'h8011_2233, 0, 0, 0, 0, 0, 0);
        // sh into upper half.
        txn(1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 5'd3, 32'h0, 0, 0, 0, 0, 0, 0);
        // misaligned lw.
        txn(0, 3'd2, 32'h8000_0002, 32'h0, 5'd9, 32'h0, 0, 0, 0, 0, 0, 0);
        // store with a load-only op.
        txn(1, 3'd4, 32'h8000_0000, 32'h1234_5678, 5'd1, 32'h0, 0, 0, 0, 0, 0, 0);
        // backpressure on both sides.
        txn(0, 3'd2, 32'h8000_0010, 32'h0, 5'd12, 32'hDEAD_BEEF, 0, 0, 5, 1, 3, 0);
        // timeout, then a late response.
        txn(0, 3'd2, 32'h8000_0020, 32'h0, 5'd4, 32'h0, 0, 1, 0, 0, 1, 0);
        // response in the last allowed cycle wins over timeout.
        txn(0, 3'd5, 32'h8000_0002, 32'h0, 5'd5, 32'h1234_5678, 0, 0, 0, TO - 1, 0, 0);
        // bus error on a store.
        txn(1, 3'd2, 32'h8000_0004, 32'hCAFE_F00D, 5'd6, 32'hFFFF_FFFF, 1, 0, 1, 2, 0, 0);
        // asynchronous reset in WAIT, then lhu.
        txn(0, 3'd2, 32'h8000_0000, 32'h0, 5'd2, 32'h0, 0, 0, 0, 0, 0, 2);
        txn(0, 3'd5, 32'h8000_0002, 32'h0, 5'd8, 32'hFFEE_0000, 0, 0, 0, 0, 0, 0);
        // reset while requesting and while presenting a result.
        txn(1, 3'd0, 32'h8000_0001, 32'h0000_00AA, 5'd10, 32'h0, 0, 0, 2, 0, 0, 1);
        txn(0, 3'd0, 32'h8000_0001, 32'h0, 5'd11, 32'h0000_8000, 0, 0, 0, 0, 2, 3);

        for (int n = 0; n < 200; n++) begin
            wren = 1'($urandom);
            op   = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 4)] : 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            rerr   = ($urandom_range(0, 7) == 0);
            noresp = ($urandom_range(0, 15) == 0);
            txn(wren, op, addr, $urandom, 5'($urandom), $urandom, rerr, noresp,
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
